// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RV32I multi-cycle control FSM (fetch/decode/exec/mem/wb/trap).
// Define CTRL_INSTRET_EN to build the retired-instruction counter; otherwise instret is tied to zero.
module multicycle_ctrl #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        br_taken,
  output logic        imem_req,
  output logic        ir_we,
  output logic [2:0]  imm_type,
  output logic        alu_sel_pc,
  output logic        alu_sel_imm,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        halt,
  output logic [1:0]  trap_cause,
  output logic [31:0] instret
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
  typedef enum logic [3:0] {
    C_NONE, C_OP, C_OPIMM, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC, C_FENCE
  } cls_t;
  localparam int WW = MAX_WAIT > 0 ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [6:0] SYSTEM = 7'b1110011;
  state_t state, nxt;
  cls_t cls, cls_dec;
  logic [6:0] opcode;
  logic [2:0] imm_dec;
  logic [1:0] cause_nxt;
  logic [WW-1:0] wait_cnt, wait_nxt;
  logic waiting, timeout;
  logic unused_instr;
  assign unused_instr = ^instr[31:7];
  assign waiting = (state == FETCH && !imem_ready) || (state == MEM && !dmem_ready);
  assign timeout = waiting && MAX_WAIT != 0 && wait_cnt == WW'(MAX_WAIT - 1);
  assign wait_nxt = waiting ? wait_cnt + WW'(1) : '0;
  assign halt = state == TRAP;
  always_comb begin
    cls_dec = C_NONE;
    imm_dec = 3'b111;
    case (opcode)
      7'b0110011: cls_dec = C_OP;
      7'b0010011: begin cls_dec = C_OPIMM;  imm_dec = 3'b000; end
      7'b0000011: begin cls_dec = C_LOAD;   imm_dec = 3'b000; end
      7'b1100111: begin cls_dec = C_JALR;   imm_dec = 3'b000; end
      7'b1100011: begin cls_dec = C_BRANCH; imm_dec = 3'b001; end
      7'b0100011: begin cls_dec = C_STORE;  imm_dec = 3'b010; end
      7'b0110111: begin cls_dec = C_LUI;    imm_dec = 3'b011; end
      7'b0010111: begin cls_dec = C_AUIPC;  imm_dec = 3'b011; end
      7'b1101111: begin cls_dec = C_JAL;    imm_dec = 3'b100; end
      7'b0001111: cls_dec = C_FENCE;
      default: ;
    endcase
  end
  always_comb begin
    nxt = state;
    cause_nxt = 2'b11;
    imem_req = 1'b0;
    ir_we = 1'b0;
    alu_sel_pc = 1'b0;
    alu_sel_imm = 1'b0;
    dmem_req = 1'b0;
    dmem_we = 1'b0;
    rf_we = 1'b0;
    wb_sel = 2'b00;
    pc_we = 1'b0;
    pc_sel = 2'b00;
    case (state)
      FETCH: begin
        imem_req = 1'b1;
        ir_we = imem_ready;
        nxt = imem_ready ? DECODE : timeout ? TRAP : FETCH;
      end
      DECODE: begin
        nxt = (opcode == SYSTEM || cls_dec == C_NONE) ? TRAP : EXEC;
        cause_nxt = opcode == SYSTEM ? 2'b01 : 2'b10;
      end
      EXEC: begin
        alu_sel_imm = !(cls == C_OP || cls == C_BRANCH);
        alu_sel_pc = cls == C_AUIPC || cls == C_JAL || cls == C_BRANCH;
        pc_we = cls == C_BRANCH || cls == C_FENCE;
        pc_sel = {1'b0, cls == C_BRANCH && br_taken};
        nxt = pc_we ? FETCH : (cls == C_LOAD || cls == C_STORE) ? MEM : WB;
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we = cls == C_STORE;
        pc_we = dmem_ready && cls == C_STORE;
        nxt = dmem_ready ? (cls == C_STORE ? FETCH : WB) : timeout ? TRAP : MEM;
      end
      WB: begin
        rf_we = 1'b1;
        pc_we = 1'b1;
        wb_sel = cls == C_LOAD ? 2'b01 : (cls == C_JAL || cls == C_JALR) ? 2'b10 : 2'b00;
        pc_sel = cls == C_JAL ? 2'b01 : cls == C_JALR ? 2'b10 : 2'b00;
        nxt = FETCH;
      end
      default: ;
    endcase
    // state is FETCH while reset is held, so requests must be masked combinationally
    if (!rst_n) begin
      imem_req = 1'b0;
      ir_we = 1'b0;
      alu_sel_pc = 1'b0;
      alu_sel_imm = 1'b0;
      dmem_req = 1'b0;
      dmem_we = 1'b0;
      rf_we = 1'b0;
      wb_sel = 2'b00;
      pc_we = 1'b0;
      pc_sel = 2'b00;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      cls <= C_NONE;
      opcode <= '0;
      imm_type <= 3'b111;
      trap_cause <= 2'b00;
      wait_cnt <= '0;
    end else begin
      state <= nxt;
      wait_cnt <= wait_nxt;
      if (state == FETCH && imem_ready) opcode <= instr[6:0];
      if (state == DECODE) begin
        cls <= cls_dec;
        imm_type <= imm_dec;
      end
      if (nxt == TRAP && state != TRAP) trap_cause <= cause_nxt;
    end
  end
`ifdef CTRL_INSTRET_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) instret <= '0;
    else if (pc_we) instret <= instret + 32'd1;
  end
`else
  assign instret = '0;
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized instruction stream checked against a per-instruction cycle-trace model.
module tb_multicycle_ctrl;
  localparam int MAX_WAIT = 15;
  localparam logic [6:0] OP = 7'b0110011, OPI = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011,
    BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111,
    FENCE = 7'b0001111, SYS = 7'b1110011;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic imem_ready = 1'b0, dmem_ready = 1'b0, br_taken = 1'b0;
  logic imem_req, ir_we, alu_sel_pc, alu_sel_imm, dmem_req, dmem_we, rf_we, pc_we, halt;
  logic [2:0] imm_type;
  logic [1:0] wb_sel, pc_sel, trap_cause;
  logic [31:0] instret;
  int total = 0, bad = 0;
  logic [2:0] m_imm = 3'b111;
  logic [1:0] m_cause = 2'b00;
  logic [31:0] m_cnt = '0;
  bit halted = 1'b0;
  wire [12:0] act = {imem_req, ir_we, alu_sel_pc, alu_sel_imm, dmem_req, dmem_we, rf_we,
                     wb_sel, pc_we, pc_sel, halt};

  multicycle_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .br_taken(br_taken), .imem_req(imem_req), .ir_we(ir_we), .imm_type(imm_type),
    .alu_sel_pc(alu_sel_pc), .alu_sel_imm(alu_sel_imm), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .rf_we(rf_we), .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel), .halt(halt),
    .trap_cause(trap_cause), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] pk(logic ireq, logic irwe, logic apc, logic aimm, logic dreq,
      logic dwe, logic rfwe, logic [1:0] wbs, logic pcwe, logic [1:0] pcs, logic hlt);
    return {ireq, irwe, apc, aimm, dreq, dwe, rfwe, wbs, pcwe, pcs, hlt};
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic bit legal(logic [6:0] op);
    return op inside {OP, OPI, LD, ST, BR, JAL, JALR, LUI, AUIPC, FENCE};
  endfunction

  function automatic logic [2:0] imm_of(logic [6:0] op);
    case (op)
      OPI, LD, JALR: return 3'b000;
      BR: return 3'b001;
      ST: return 3'b010;
      LUI, AUIPC: return 3'b011;
      JAL: return 3'b100;
      default: return 3'b111;
    endcase
  endfunction

  task automatic retire();
`ifdef CTRL_INSTRET_EN
    m_cnt = m_cnt + 32'd1;
`endif
  endtask

  // starts and ends on a falling edge
  task automatic step(string tag, logic ir, logic dr, logic br, logic [31:0] iw, logic [12:0] e);
    imem_ready = ir;
    dmem_ready = dr;
    br_taken = br;
    instr = iw;
    #1;
    check({tag, ".ctl"}, 32'(act), 32'(e));
    check({tag, ".imm"}, 32'(imm_type), 32'(m_imm));
    check({tag, ".cause"}, 32'(trap_cause), 32'(m_cause));
    check({tag, ".instret"}, instret, m_cnt);
    @(negedge clk);
  endtask

  task automatic do_reset(string tag);
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    m_imm = 3'b111;
    m_cause = 2'b00;
    m_cnt = '0;
    halted = 1'b0;
    check({tag, ".ctl"}, 32'(act), 32'd0);
    check({tag, ".imm"}, 32'(imm_type), 32'd7);
    check({tag, ".cause"}, 32'(trap_cause), 32'd0);
    check({tag, ".instret"}, instret, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle_trap();
    for (int i = 0; i < 3; i++)
      step("trap", rb(), rb(), rb(), $urandom, pk(0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 1));
  endtask

  task automatic run(logic [6:0] op, int fw, int mw, bit abort);
    logic [31:0] w;
    logic r, br, st;
    w = $urandom;
    w[6:0] = op;
    st = op == ST;
    for (int i = 0; i <= fw; i++) begin
      r = i == fw;
      if (!r && i == MAX_WAIT - 1) begin
        step("fetch_to", 1'b0, rb(), rb(), $urandom, pk(1, 0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0));
        m_cause = 2'b11;
        halted = 1'b1;
        return;
      end
      step("fetch", r, rb(), rb(), r ? w : $urandom, pk(1, r, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0));
    end
    step("decode", rb(), rb(), rb(), $urandom, pk(0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0));
    m_imm = imm_of(op);
    if (!legal(op)) begin
      m_cause = op == SYS ? 2'b01 : 2'b10;
      halted = 1'b1;
      return;
    end
    br = rb();
    if (op == BR || op == FENCE) begin
      step("exec_pc", rb(), rb(), br, $urandom,
           pk(0, 0, op == BR, op == FENCE, 0, 0, 0, 2'd0, 1, (op == BR && br) ? 2'd1 : 2'd0, 0));
      retire();
      return;
    end
    step("exec", rb(), rb(), br, $urandom,
         pk(0, 0, op == AUIPC || op == JAL, op != OP, 0, 0, 0, 2'd0, 0, 2'd0, 0));
    if (op == LD || st) begin
      for (int i = 0; i <= mw; i++) begin
        r = i == mw;
        if (abort && i == 1) begin
          do_reset("mid_mem");
          return;
        end
        if (!r && i == MAX_WAIT - 1) begin
          step("mem_to", rb(), 1'b0, rb(), $urandom, pk(0, 0, 0, 0, 1, st, 0, 2'd0, 0, 2'd0, 0));
          m_cause = 2'b11;
          halted = 1'b1;
          return;
        end
        step("mem", rb(), r, rb(), $urandom, pk(0, 0, 0, 0, 1, st, 0, 2'd0, st && r, 2'd0, 0));
      end
      if (st) begin
        retire();
        return;
      end
    end
    step("wb", rb(), rb(), rb(), $urandom,
         pk(0, 0, 0, 0, 0, 0, 1, op == LD ? 2'd1 : (op == JAL || op == JALR) ? 2'd2 : 2'd0,
            1, op == JAL ? 2'd1 : op == JALR ? 2'd2 : 2'd0, 0));
    retire();
  endtask

  initial begin
    logic [6:0] kinds [10];
    logic [6:0] op;
    int fw, mw;
    kinds = '{OP, OPI, LD, ST, BR, JAL, JALR, LUI, AUIPC, FENCE};
    @(negedge clk);
    do_reset("reset");
    run(OPI, 0, 0, 0);
    run(BR, 0, 0, 0);
    run(LD, 0, 3, 0);
    run(ST, 0, 0, 0);
    run(JAL, 0, 0, 0);
    run(JALR, 0, 0, 0);
    run(LUI, 2, 0, 0);
    run(AUIPC, 1, 0, 0);
    run(OP, 0, 0, 0);
    run(FENCE, 0, 0, 0);
    run(OPI, MAX_WAIT - 1, 0, 0);
    run(LD, 0, MAX_WAIT - 1, 0);
    run(7'h7F, 0, 0, 0);
    idle_trap();
    do_reset("rst_ill");
    run(OPI, MAX_WAIT, 0, 0);
    idle_trap();
    do_reset("rst_fto");
    run(ST, 0, MAX_WAIT + 2, 0);
    idle_trap();
    do_reset("rst_mto");
    run(LD, 0, 5, 1);
    run(OPI, 0, 0, 0);
    run(OPI, 1, 0, 0);
    run(OPI, 0, 0, 0);
    run(SYS, 0, 0, 0);
    idle_trap();
    do_reset("rst_sys");
    for (int n = 0; n < 300; n++) begin
      op = ($urandom % 10 == 0) ? 7'($urandom) : kinds[$urandom % 10];
      fw = ($urandom % 8 == 0) ? int'($urandom_range(MAX_WAIT - 2, MAX_WAIT + 1)) : int'($urandom_range(0, 2));
      mw = ($urandom % 8 == 0) ? int'($urandom_range(MAX_WAIT - 2, MAX_WAIT + 1)) : int'($urandom_range(0, 3));
      run(op, fw, mw, 1'b0);
      if (halted) begin
        idle_trap();
        do_reset("rnd_rst");
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
